// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage access sequencer.
// Contents: sequencer state enum, RV32 load/store funct3 codes, default widths,
// and access_size() which returns the access width in bytes for a funct3.
package lsu_pkg;

    localparam int unsigned DM_ADDRESS_DEF = 9;
    localparam int unsigned DATA_W_DEF     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD2 = 2'd1,
        STORE = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size in bytes; unknown codes behave as a full word.
    function automatic logic [2:0] access_size(input logic [2:0] funct3,
                                               input logic       is_store);
        logic [2:0] sz;
        sz = 3'd4;
        if (is_store) begin
            case (funct3)
                F3_SB:   sz = 3'd1;
                F3_SH:   sz = 3'd2;
                default: sz = 3'd4;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: sz = 3'd1;
                F3_LH, F3_LHU: sz = 3'd2;
                default:       sz = 3'd4;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Bundle of the pipeline request side and the data-memory side of the
// MEM-stage access sequencer.
//   slave  : the sequencer (consumes req_* and mem_rd, drives the rest)
//   master : the pipeline/memory environment around it
interface mem_access_sequencer_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  req_read;
    logic                  req_write;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  stall;
    logic [DATA_W-1:0]     load_data;
    logic                  misaligned;
    logic                  mem_read;
    logic                  mem_write;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wd;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rd;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, req_funct3, mem_rd,
        output stall, load_data, misaligned,
               mem_read, mem_write, mem_addr, mem_wd, mem_funct3
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata, req_funct3, mem_rd,
        input  stall, load_data, misaligned,
               mem_read, mem_write, mem_addr, mem_wd, mem_funct3
    );
endinterface

// File: rtl/load_extract.sv
// Combinational load result extraction.
//   window   : {hi_word, lo_word} covering the accessed bytes
//   offset   : byte offset of the access within lo_word
//   funct3   : load type (LB/LH/LW/LBU/LHU; others behave as LW)
//   result_c : sign/zero-extended 32-bit load value
module load_extract
    import lsu_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result_c
);

    logic [5:0]  base;
    logic [31:0] sel;

    assign base = {1'b0, offset, 3'b000};
    assign sel  = window[base +: 32];

    // Extend the selected low bytes according to the load type.
    always_comb begin
        result_c = sel;
        case (funct3)
            F3_LB:   result_c = {{24{sel[7]}}, sel[7:0]};
            F3_LH:   result_c = {{16{sel[15]}}, sel[15:0]};
            F3_LBU:  result_c = {24'd0, sel[7:0]};
            F3_LHU:  result_c = {16'd0, sel[15:0]};
            default: result_c = sel;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage load/store sequencer between EX/MEM and a data memory that only
// supports LW reads and SB/SW writes. Word-crossing loads take two reads;
// SH and misaligned SW are split into byte stores. stall is high while a
// multi-cycle sequence is still in progress.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : request side (req_*, stall, load_data, misaligned) and
//                memory side (mem_read/write/addr/wd/funct3, mem_rd)
// Build option: define MISALIGN_TRAP_EN to suppress misaligned accesses and
// flag them on misaligned instead of splitting them.
module mem_access_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_access_sequencer_if.slave  bus
);

    state_t              state, state_nxt;
    logic [1:0]          cnt, cnt_nxt;
    logic [DATA_W-1:0]   lo_reg, lo_nxt;

    logic                  is_load, is_store;
    logic [1:0]            off;
    logic [2:0]            size;
    logic                  load_cross, store_split, trap;
    logic [1:0]            k;
    logic                  last;
    logic [7:0]            lane;
    logic [DM_ADDRESS-1:0] word_addr, next_word, byte_addr;
    logic [2*DATA_W-1:0]   window;
    logic [DATA_W-1:0]     ext_data;

    // Request decode; a read wins over a simultaneous write.
    assign is_load   = bus.req_read;
    assign is_store  = bus.req_write & ~bus.req_read;
    assign off       = bus.req_addr[1:0];
    assign size      = access_size(bus.req_funct3, is_store);
    assign load_cross  = is_load  && ((3'(off) + size) > 3'd4);
    assign store_split = is_store && ((size == 3'd2) || ((size == 3'd4) && (off != 2'd0)));

`ifdef MISALIGN_TRAP_EN
    assign trap = (is_load || is_store) &&
                  (((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'd0)));
`else
    assign trap = 1'b0;
`endif

    // Byte-store sequencing: k=0 is issued from IDLE, later bytes from STORE.
    assign k         = (state == STORE) ? cnt : 2'd0;
    assign last      = (3'(k) == (size - 3'd1));
    assign lane      = bus.req_wdata[{k, 3'b000} +: 8];
    assign byte_addr = bus.req_addr + DM_ADDRESS'(k);
    assign word_addr = {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
    assign next_word = word_addr + DM_ADDRESS'(4);

    // Second read of a crossing load pairs the new word with the saved one.
    assign window = (state == LOAD2) ? {bus.mem_rd, lo_reg}
                                     : {{DATA_W{1'b0}}, bus.mem_rd};

    load_extract u_load_extract (
        .window   (window),
        .offset   (off),
        .funct3   (bus.req_funct3),
        .result_c (ext_data)
    );

    // State, byte counter and saved low word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            lo_reg <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            lo_reg <= lo_nxt;
        end
    end

    // Next state and same-cycle memory/pipeline outputs.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        lo_nxt         = lo_reg;
        bus.stall      = 1'b0;
        bus.misaligned = 1'b0;
        bus.load_data  = ext_data;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = bus.req_addr;
        bus.mem_wd     = bus.req_wdata;
        bus.mem_funct3 = F3_SW;

        case (state)
            IDLE: begin
                if (trap) begin
                    bus.misaligned = 1'b1;
                    bus.load_data  = '0;
                end else if (is_load) begin
                    bus.mem_read = 1'b1;
                    bus.mem_addr = word_addr;
                    if (load_cross) begin
                        bus.stall = 1'b1;
                        lo_nxt    = bus.mem_rd;
                        state_nxt = LOAD2;
                    end
                end else if (is_store) begin
                    bus.mem_write = 1'b1;
                    if (store_split) begin
                        bus.mem_funct3 = F3_SB;
                        bus.mem_addr   = byte_addr;
                        bus.mem_wd     = {4{lane}};
                        bus.stall      = 1'b1;
                        cnt_nxt        = 2'd1;
                        state_nxt      = STORE;
                    end else begin
                        bus.mem_funct3 = (size == 3'd1) ? F3_SB : F3_SW;
                    end
                end
            end
            LOAD2: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = next_word;
                state_nxt    = IDLE;
            end
            STORE: begin
                bus.mem_write  = 1'b1;
                bus.mem_funct3 = F3_SB;
                bus.mem_addr   = byte_addr;
                bus.mem_wd     = {4{lane}};
                if (last) begin
                    cnt_nxt   = 2'd0;
                    state_nxt = IDLE;
                end else begin
                    bus.stall = 1'b1;
                    cnt_nxt   = cnt + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Reset silences the pipeline and memory controls immediately.
        if (reset) begin
            bus.stall      = 1'b0;
            bus.misaligned = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.load_data  = '0;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer with a byte-array
// data memory (combinational LW read, SB/SW write on the falling edge).
module tb_mem_access_sequencer;
    import lsu_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [7:0] mem [512];

    mem_access_sequencer_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    mem_access_sequencer #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory read port: word read at the aligned address.
    always_comb begin
        logic [8:0] a;
        a = {bus.mem_addr[8:2], 2'b00};
        bus.mem_rd = {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
    end

    // Data memory write port.
    always @(negedge clk) begin
        if (bus.mem_write) begin
            if (bus.mem_funct3 == 3'b000) begin
                mem[bus.mem_addr] <= bus.mem_wd[7:0];
            end else begin
                mem[{bus.mem_addr[8:2], 2'b00}]         <= bus.mem_wd[7:0];
                mem[{bus.mem_addr[8:2], 2'b00} + 9'd1]  <= bus.mem_wd[15:8];
                mem[{bus.mem_addr[8:2], 2'b00} + 9'd2]  <= bus.mem_wd[23:16];
                mem[{bus.mem_addr[8:2], 2'b00} + 9'd3]  <= bus.mem_wd[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: apply reset and request just after the edge, settle, return.
    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3);
        @(posedge clk);
        #1;
        reset          = rst;
        bus.req_read   = rd;
        bus.req_write  = wr;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_funct3 = f3;
        #2;
    endtask

    task automatic store_word(input logic [8:0] a, input logic [31:0] d);
        drive(1'b0, 1'b0, 1'b1, a, d, F3_SW);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.req_read   = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = F3_LW;

        // Outputs quiet while reset is held, even with requests present.
        drive(1'b1, 1'b1, 1'b0, 9'h013, 32'h0, F3_LW);
        check("rst_stall_ld", bus.stall, 0);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_load_data", bus.load_data, 0);
        drive(1'b1, 1'b0, 1'b1, 9'h013, 32'h12345678, F3_SW);
        check("rst_stall_st", bus.stall, 0);
        check("rst_mem_write", bus.mem_write, 0);

        // Aligned store then single-cycle loads.
        store_word(9'h010, 32'h8899AABB);
        check("sw_pass_write", bus.mem_write, 1);
        check("sw_pass_f3", bus.mem_funct3, 3'b010);
        check("sw_pass_stall", bus.stall, 0);
        drive(1'b0, 1'b1, 1'b0, 9'h012, 32'h0, F3_LB);
        check("lb_data", bus.load_data, 32'hFFFFFF99);
        check("lb_stall", bus.stall, 0);
        check("lb_addr", bus.mem_addr, 9'h010);
        check("lb_f3", bus.mem_funct3, 3'b010);
        drive(1'b0, 1'b1, 1'b0, 9'h013, 32'h0, F3_LBU);
        check("lbu_data", bus.load_data, 32'h00000088);
        drive(1'b0, 1'b1, 1'b0, 9'h012, 32'h0, F3_LH);
        check("lh_data", bus.load_data, 32'hFFFF8899);
        drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
        check("lw_aligned", bus.load_data, 32'h8899AABB);

        // Word-crossing loads.
        store_word(9'h010, 32'h44332211);
        store_word(9'h014, 32'h88776655);
        drive(1'b0, 1'b1, 1'b0, 9'h013, 32'h0, F3_LW);
        check("lwx_c1_stall", bus.stall, 1);
        check("lwx_c1_addr", bus.mem_addr, 9'h010);
        drive(1'b0, 1'b1, 1'b0, 9'h013, 32'h0, F3_LW);
        check("lwx_c2_stall", bus.stall, 0);
        check("lwx_c2_addr", bus.mem_addr, 9'h014);
        check("lwx_data", bus.load_data, 32'h77665544);
        drive(1'b0, 1'b1, 1'b0, 9'h013, 32'h0, F3_LHU);
        check("lhux_c1_stall", bus.stall, 1);
        drive(1'b0, 1'b1, 1'b0, 9'h013, 32'h0, F3_LHU);
        check("lhux_c2_stall", bus.stall, 0);
        check("lhux_data", bus.load_data, 32'h00005544);

        // Read wins when both requests are raised.
        drive(1'b0, 1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, F3_LW);
        check("rw_no_write", bus.mem_write, 0);
        check("rw_read", bus.mem_read, 1);
        check("rw_data", bus.load_data, 32'h44332211);
        drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
        check("rw_unchanged", bus.load_data, 32'h44332211);

        // SH split into two byte stores; SB passes through.
        store_word(9'h020, 32'h44332211);
        drive(1'b0, 1'b0, 1'b1, 9'h020, 32'h1234BEEF, F3_SH);
        check("sh_b0_f3", bus.mem_funct3, 3'b000);
        check("sh_b0_addr", bus.mem_addr, 9'h020);
        check("sh_b0_wd", bus.mem_wd, 32'hEFEFEFEF);
        check("sh_b0_stall", bus.stall, 1);
        drive(1'b0, 1'b0, 1'b1, 9'h020, 32'h1234BEEF, F3_SH);
        check("sh_b1_addr", bus.mem_addr, 9'h021);
        check("sh_b1_wd", bus.mem_wd, 32'hBEBEBEBE);
        check("sh_b1_stall", bus.stall, 0);
        drive(1'b0, 1'b1, 1'b0, 9'h020, 32'h0, F3_LW);
        check("sh_result", bus.load_data, 32'h4433BEEF);
        drive(1'b0, 1'b0, 1'b1, 9'h022, 32'h123456A5, F3_SB);
        check("sb_f3", bus.mem_funct3, 3'b000);
        check("sb_addr", bus.mem_addr, 9'h022);
        check("sb_stall", bus.stall, 0);
        drive(1'b0, 1'b1, 1'b0, 9'h020, 32'h0, F3_LW);
        check("sb_result", bus.load_data, 32'h44A5BEEF);

`ifndef MISALIGN_TRAP_EN
        // Misaligned SW wrapping past the top of memory.
        store_word(9'h1FC, 32'h0);
        store_word(9'h000, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 9'h1FE, 32'hDEADBEEF, F3_SW);
        check("sww_b0_addr", bus.mem_addr, 9'h1FE);
        check("sww_b0_wd", bus.mem_wd, 32'hEFEFEFEF);
        check("sww_b0_stall", bus.stall, 1);
        check("sww_misaligned", bus.misaligned, 0);
        drive(1'b0, 1'b0, 1'b1, 9'h1FE, 32'hDEADBEEF, F3_SW);
        check("sww_b1_addr", bus.mem_addr, 9'h1FF);
        check("sww_b1_stall", bus.stall, 1);
        drive(1'b0, 1'b0, 1'b1, 9'h1FE, 32'hDEADBEEF, F3_SW);
        check("sww_b2_addr", bus.mem_addr, 9'h000);
        check("sww_b2_wd", bus.mem_wd, 32'hADADADAD);
        check("sww_b2_stall", bus.stall, 1);
        drive(1'b0, 1'b0, 1'b1, 9'h1FE, 32'hDEADBEEF, F3_SW);
        check("sww_b3_addr", bus.mem_addr, 9'h001);
        check("sww_b3_wd", bus.mem_wd, 32'hDEDEDEDE);
        check("sww_b3_stall", bus.stall, 0);
        drive(1'b0, 1'b1, 1'b0, 9'h1FC, 32'h0, F3_LW);
        check("sww_top_word", bus.load_data, 32'hBEEF0000);
        drive(1'b0, 1'b1, 1'b0, 9'h000, 32'h0, F3_LW);
        check("sww_low_word", bus.load_data, 32'h0000DEAD);
        drive(1'b0, 1'b1, 1'b0, 9'h1FE, 32'h0, F3_LW);
        check("lww_c1_stall", bus.stall, 1);
        drive(1'b0, 1'b1, 1'b0, 9'h1FE, 32'h0, F3_LW);
        check("lww_c2_addr", bus.mem_addr, 9'h000);
        check("lww_data", bus.load_data, 32'hDEADBEEF);

        // Reset during the second byte of a misaligned SW aborts the rest.
        store_word(9'h040, 32'h0);
        store_word(9'h044, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 9'h041, 32'h11223344, F3_SW);
        check("abort_b0_stall", bus.stall, 1);
        drive(1'b1, 1'b0, 1'b1, 9'h041, 32'h11223344, F3_SW);
        check("abort_rst_write", bus.mem_write, 0);
        check("abort_rst_stall", bus.stall, 0);
        drive(1'b0, 1'b1, 1'b0, 9'h040, 32'h0, F3_LW);
        check("abort_idle_stall", bus.stall, 0);
        check("abort_idle_write", bus.mem_write, 0);
        check("abort_word0", bus.load_data, 32'h00004400);
        drive(1'b0, 1'b1, 1'b0, 9'h044, 32'h0, F3_LW);
        check("abort_word1", bus.load_data, 32'h00000000);
`else
        // Misaligned accesses trap; aligned SH still splits.
        drive(1'b0, 1'b1, 1'b0, 9'h005, 32'h0, F3_LW);
        check("trap_lw_flag", bus.misaligned, 1);
        check("trap_lw_read", bus.mem_read, 0);
        check("trap_lw_stall", bus.stall, 0);
        check("trap_lw_data", bus.load_data, 0);
        drive(1'b0, 1'b0, 1'b1, 9'h005, 32'h0000BEEF, F3_SH);
        check("trap_sh_flag", bus.misaligned, 1);
        check("trap_sh_write", bus.mem_write, 0);
        drive(1'b0, 1'b0, 1'b1, 9'h004, 32'h0000BEEF, F3_SH);
        check("trap_shal_flag", bus.misaligned, 0);
        check("trap_shal_b0_addr", bus.mem_addr, 9'h004);
        check("trap_shal_b0_stall", bus.stall, 1);
        drive(1'b0, 1'b0, 1'b1, 9'h004, 32'h0000BEEF, F3_SH);
        check("trap_shal_b1_addr", bus.mem_addr, 9'h005);
        check("trap_shal_b1_stall", bus.stall, 0);
        drive(1'b0, 1'b1, 1'b0, 9'h013, 32'h0, F3_LHU);
        check("trap_lhu_flag", bus.misaligned, 1);
`endif

        drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, F3_LW);
        check("idle_read", bus.mem_read, 0);
        check("idle_write", bus.mem_write, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
